// File: rtl/timer_request_controller_pkg.sv
// Shared definitions for the timer request controller: state encoding,
// default timing parameters and the reference timer threshold.
package timer_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_CLEAR = S_CLEAR,
    ST_ARM   = S_ARM,
    ST_WAIT  = S_WAIT,
    ST_DONE  = S_DONE,
    ST_ERR   = S_ERR
  } state_e;

  localparam int unsigned DEFAULT_CLEAR_CYCLES = 1;
  localparam int unsigned DEFAULT_MAX_WAIT     = 16;
  localparam int unsigned TIMER_THRESHOLD      = 4;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/timer_request_controller_if.sv
// Request/timer signal bundle. master = the controller, slave = the control FSM
// plus timer that surround it.
interface timer_request_controller_if;
  logic start_req;
  logic abort;
  logic timer_expired;
  logic timer_clear;
  logic start_ack;
  logic done;
  logic timeout_err;
  logic busy;

  modport master (
    input  start_req, abort, timer_expired,
    output timer_clear, start_ack, done, timeout_err, busy
  );

  modport slave (
    output start_req, abort, timer_expired,
    input  timer_clear, start_ack, done, timeout_err, busy
  );
endinterface

// File: rtl/timer_request_controller_sat_cycle_counter.sv
// Up-counter with enable and synchronous clear that holds at MAX_COUNT
// instead of wrapping.
module sat_cycle_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX_VAL)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/timer_request_controller.sv
// Initiator side of the timer interface: clears the timer, waits for expiry and
// reports done, or timeout_err on a stale or dead timer.
module timer_request_controller
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES,
  parameter int unsigned MAX_WAIT     = DEFAULT_MAX_WAIT
) (
  input  logic                        clock,
  input  logic                        clear_n,
  timer_request_controller_if.master  bus
);

  localparam int unsigned CLR_W = cnt_width(CLEAR_CYCLES);
  localparam int unsigned WD_W  = $clog2(MAX_WAIT + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_WAIT - 1);

  state_e state_q, state_d;
  logic   timer_clear_q, timer_clear_d;
  logic   start_ack_q, start_ack_d;
  logic   done_q, done_d;
  logic   timeout_err_q, timeout_err_d;
  logic   busy_q, busy_d;

  logic [CLR_W-1:0] clr_cnt;
  logic [WD_W-1:0]  wd_cnt;

  sat_cycle_counter #(.WIDTH(CLR_W), .MAX_COUNT(CLEAR_CYCLES)) u_clear_len (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (state_q != ST_CLEAR),
    .en      (state_q == ST_CLEAR),
    .count   (clr_cnt)
  );

  sat_cycle_counter #(.WIDTH(WD_W), .MAX_COUNT(MAX_WAIT)) u_watchdog (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (state_q == ST_ARM),
    .en      (state_q == ST_WAIT),
    .count   (wd_cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start_req) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (bus.abort)                state_d = ST_IDLE;
        else if (clr_cnt == CLR_LAST) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (bus.abort)              state_d = ST_IDLE;
        else if (bus.timer_expired) state_d = ST_ERR;
        else                        state_d = ST_WAIT;
      end
      // The cycle in which the watchdog would step to MAX_WAIT is the last WAIT cycle.
      ST_WAIT: begin
        if (bus.abort)              state_d = ST_IDLE;
        else if (bus.timer_expired) state_d = ST_DONE;
        else if (wd_cnt >= WD_LAST) state_d = ST_ERR;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    timer_clear_d = (state_d == ST_CLEAR);
    start_ack_d   = (state_q == ST_IDLE) && (state_d == ST_CLEAR);
    done_d        = (state_d == ST_DONE);
    timeout_err_d = (state_d == ST_ERR);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q       <= ST_IDLE;
      timer_clear_q <= 1'b0;
      start_ack_q   <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_clear_q <= timer_clear_d;
      start_ack_q   <= start_ack_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.timer_clear = timer_clear_q;
  assign bus.start_ack   = start_ack_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_timer_request_controller.sv
// Scoreboard bench: each test queues the output events it expects (kind and
// cycle); a negedge monitor pops and compares every event the DUT produces.
module tb_timer_request_controller;
  import timer_ctrl_pkg::*;

  typedef enum int {EV_BUSY_UP, EV_ACK, EV_CLR, EV_DONE, EV_ERR, EV_BUSY_DN} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
  } ev_t;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  int   cyc     = 0;
  int   t0      = 0;
  int   checks  = 0;
  int   failures = 0;
  int   tmode   = 0;   // 0: timer model, 1: never expires, 2: always expired
  int unsigned tcount = 0;
  logic busy_prev = 1'b0;
  ev_t  exp_q[$];

  timer_request_controller_if bus();

  timer_request_controller #(
    .CLEAR_CYCLES (DEFAULT_CLEAR_CYCLES),
    .MAX_WAIT     (DEFAULT_MAX_WAIT)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Non-recycling timer: restarts on timer_clear, holds once it reaches the threshold.
  always @(posedge clock) begin
    if (!clear_n || bus.timer_clear) tcount <= 0;
    else if (tcount < TIMER_THRESHOLD) tcount <= tcount + 1;
  end

  assign bus.timer_expired = (tmode == 1) ? 1'b0 :
                             (tmode == 2) ? 1'b1 : (tcount >= TIMER_THRESHOLD);

  task automatic observe(input ev_e kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual=%s@%0d required=none", kind.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        failures++;
        $display("FAIL event actual=%s@%0d required=%s@%0d",
                 kind.name(), cyc, e.kind.name(), e.cyc);
      end else begin
        $display("ok   event %s@%0d", kind.name(), cyc);
      end
    end
  endtask

  always @(negedge clock) begin
    if (bus.busy && !busy_prev) observe(EV_BUSY_UP);
    if (bus.start_ack)          observe(EV_ACK);
    if (bus.timer_clear)        observe(EV_CLR);
    if (bus.done)               observe(EV_DONE);
    if (bus.timeout_err)        observe(EV_ERR);
    if (!bus.busy && busy_prev) observe(EV_BUSY_DN);
    busy_prev = bus.busy;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_test();
    t0 = cyc;
  endtask

  task automatic goto_cycle(input int rel);
    while (cyc < t0 + rel) step();
  endtask

  task automatic expect_ev(input ev_e k, input int rel);
    ev_t e;
    e.kind = k;
    e.cyc  = t0 + rel;
    exp_q.push_back(e);
  endtask

  // A request accepted at rel: busy rises, ack and the single clear cycle coincide.
  task automatic expect_start(input int rel);
    expect_ev(EV_BUSY_UP, rel);
    expect_ev(EV_ACK, rel);
    expect_ev(EV_CLR, rel);
  endtask

  task automatic end_test(input string name, input int last_rel);
    goto_cycle(last_rel + 3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_events actual=%0d_outstanding required=0 first=%s@%0d",
               name, exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
      exp_q.delete();
    end else begin
      $display("ok   %s all expected events seen", name);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [4:0] act;
    act = {bus.busy, bus.start_ack, bus.timer_clear, bus.done, bus.timeout_err};
    checks++;
    if (act != 5'b0) begin
      failures++;
      $display("FAIL %s outputs actual=%b required=00000", name, act);
    end else begin
      $display("ok   %s outputs=%b", name, act);
    end
  endtask

  initial begin
    bus.start_req = 1'b0;
    bus.abort     = 1'b0;

    // Reset held two cycles with start_req high: nothing may happen until release.
    bus.start_req = 1'b1;
    step(); check_reset_outputs("reset_c0");
    step(); check_reset_outputs("reset_c1");
    clear_n = 1'b1;
    begin_test();
    expect_start(1); expect_ev(EV_DONE, 7); expect_ev(EV_BUSY_DN, 8);
    goto_cycle(1); bus.start_req = 1'b0;
    end_test("after_reset", 8);

    // Normal request: ack@1, done@7, busy low @8.
    begin_test();
    bus.start_req = 1'b1;
    expect_start(1); expect_ev(EV_DONE, 7); expect_ev(EV_BUSY_DN, 8);
    goto_cycle(1); bus.start_req = 1'b0;
    end_test("normal", 8);

    // Abort in WAIT.
    begin_test();
    bus.start_req = 1'b1;
    expect_start(1); expect_ev(EV_BUSY_DN, 5);
    goto_cycle(1); bus.start_req = 1'b0;
    goto_cycle(4); bus.abort = 1'b1;
    goto_cycle(5); bus.abort = 1'b0;
    end_test("abort_wait", 8);

    // Dead timer: watchdog fires MAX_WAIT cycles after WAIT entry (cycle 3).
    tmode = 1;
    begin_test();
    bus.start_req = 1'b1;
    expect_start(1);
    expect_ev(EV_ERR, 3 + int'(DEFAULT_MAX_WAIT));
    expect_ev(EV_BUSY_DN, 4 + int'(DEFAULT_MAX_WAIT));
    goto_cycle(1); bus.start_req = 1'b0;
    end_test("dead_timer", 4 + int'(DEFAULT_MAX_WAIT));
    tmode = 0;

    // Stale timer: expired already seen in ARM.
    tmode = 2;
    begin_test();
    bus.start_req = 1'b1;
    expect_start(1); expect_ev(EV_ERR, 3); expect_ev(EV_BUSY_DN, 4);
    goto_cycle(1); bus.start_req = 1'b0;
    end_test("stale_timer", 4);
    tmode = 0;

    // Abort in the same cycle the timer expires (cycle 6): abort wins.
    begin_test();
    bus.start_req = 1'b1;
    expect_start(1); expect_ev(EV_BUSY_DN, 7);
    goto_cycle(1); bus.start_req = 1'b0;
    goto_cycle(6); bus.abort = 1'b1;
    goto_cycle(7); bus.abort = 1'b0;
    end_test("abort_vs_expiry", 7);

    // start_req held: re-accepted one cycle after each return to IDLE (acks @1, @9, @17).
    begin_test();
    bus.start_req = 1'b1;
    for (int r = 0; r < 3; r++) begin
      expect_start(1 + 8 * r);
      expect_ev(EV_DONE, 7 + 8 * r);
      expect_ev(EV_BUSY_DN, 8 + 8 * r);
    end
    goto_cycle(17); bus.start_req = 1'b0;
    end_test("back_to_back", 24);

    // Abort during DONE is ignored.
    begin_test();
    bus.start_req = 1'b1;
    expect_start(1); expect_ev(EV_DONE, 7); expect_ev(EV_BUSY_DN, 8);
    goto_cycle(1); bus.start_req = 1'b0;
    goto_cycle(7); bus.abort = 1'b1;
    goto_cycle(8); bus.abort = 1'b0;
    end_test("abort_in_done", 8);

    // Abort in the first CLEAR cycle: ack already issued, then straight back to IDLE.
    begin_test();
    bus.start_req = 1'b1;
    expect_start(1); expect_ev(EV_BUSY_DN, 2);
    goto_cycle(1); bus.start_req = 1'b0; bus.abort = 1'b1;
    goto_cycle(2); bus.abort = 1'b0;
    end_test("abort_clear", 6);

    // Reset asserted mid-WAIT.
    begin_test();
    bus.start_req = 1'b1;
    expect_start(1); expect_ev(EV_BUSY_DN, 5);
    goto_cycle(1); bus.start_req = 1'b0;
    goto_cycle(4); clear_n = 1'b0;
    goto_cycle(5); clear_n = 1'b1;
    check_reset_outputs("reset_mid_wait");
    end_test("reset_mid_wait", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
